// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Function : 8N1 UART receiver with 16x oversampling, start-bit glitch
//            rejection and stop-bit framing check.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200
) (
    input  logic       clock50,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int TICK_DIV = (CLK_HZ + BAUD * 8) / (BAUD * 16);
    localparam int DIV_W    = $clog2(TICK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        WAIT_HI = 3'd4
    } state_t;

    state_t           state_q;
    logic             rx_meta_q;
    logic             rx_s_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             tick;
    logic [3:0]       tick_cnt_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       shift_q;

    assign tick  = (div_q == DIV_LAST);
    assign div_d = tick ? '0 : div_q + DIV_W'(1);
    assign busy  = (state_q != IDLE);

    always_ff @(posedge clock50 or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            div_q      <= '0;
            tick_cnt_q <= 4'd0;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'd0;
            data       <= 8'd0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            div_q     <= div_d;
            valid     <= 1'b0;
            frame_err <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        // Align the bit-phase grid to the detected falling edge
                        state_q    <= START;
                        div_q      <= '0;
                        tick_cnt_q <= 4'd0;
                    end
                end

                START: begin
                    if (tick) begin
                        if (tick_cnt_q == 4'd7) begin
                            tick_cnt_q <= 4'd0;
                            bit_cnt_q  <= 3'd0;
                            state_q    <= rx_s_q ? IDLE : DATA;
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 4'd1;
                        end
                    end
                end

                DATA: begin
                    if (tick) begin
                        if (tick_cnt_q == 4'd15) begin
                            tick_cnt_q <= 4'd0;
                            shift_q    <= {rx_s_q, shift_q[7:1]};
                            bit_cnt_q  <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                state_q <= STOP;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 4'd1;
                        end
                    end
                end

                STOP: begin
                    if (tick) begin
                        if (tick_cnt_q == 4'd15) begin
                            // Leave at mid stop bit so a back-to-back start edge is not missed
                            tick_cnt_q <= 4'd0;
                            if (rx_s_q) begin
                                data    <= shift_q;
                                valid   <= 1'b1;
                                state_q <= IDLE;
                            end else begin
                                frame_err <= 1'b1;
                                state_q   <= WAIT_HI;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 4'd1;
                        end
                    end
                end

                WAIT_HI: begin
                    if (rx_s_q) begin
                        state_q <= IDLE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Function : Self-checking bench for uart_rx using a byte-queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    logic       clock50 = 1'b0;
    logic       reset   = 1'b1;
    logic       rx      = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    uart_rx #(
        .CLK_HZ(50_000_000),
        .BAUD  (115200)
    ) dut (
        .clock50  (clock50),
        .reset    (reset),
        .rx       (rx),
        .data     (data),
        .valid    (valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #10 clock50 = ~clock50;

    int         n_checks  = 0;
    int         n_pass    = 0;
    logic [7:0] exp_q[$];
    logic [7:0] last_good = 8'd0;
    logic [7:0] mon_exp;
    int         valid_cnt = 0;
    int         ferr_cnt  = 0;
    int         exp_valid = 0;
    int         exp_ferr  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: every delivered byte must be the oldest byte sent with a good stop bit
    always @(negedge clock50) begin
        if (!reset) begin
            if (valid && frame_err) begin
                check("valid_ferr_exclusive", 32'(valid & frame_err), 32'd0);
            end
            if (valid) begin
                valid_cnt++;
                if (exp_q.size() == 0) begin
                    check("spurious_valid", 32'(valid), 32'd0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("rx_data", 32'(data), 32'(mon_exp));
                    last_good = mon_exp;
                end
            end
            if (frame_err) begin
                ferr_cnt++;
                check("ferr_data_hold", 32'(data), 32'(last_good));
            end
        end
    end

    // Drive the first nbits of a frame (start, 8 data LSB first, stop)
    task automatic send(input logic [7:0] b, input int per, input logic stop_v, input int nbits);
        logic [9:0] f;
        f = {stop_v, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            rx = f[i];
            repeat (per) @(negedge clock50);
        end
    endtask

    task automatic send_good(input logic [7:0] b, input int per);
        exp_q.push_back(b);
        exp_valid++;
        send(b, per, 1'b1, 10);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clock50);
    endtask

    task automatic wait_not_busy(input string tag);
        int k;
        k = 0;
        while (busy && k < 6000) begin
            @(negedge clock50);
            k++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        #(20 * 150_000);
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int per;
        int v0;
        int f0;
        logic [7:0] b;

        repeat (5) @(negedge clock50);
        check("reset_data", 32'(data), 32'd0);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_ferr", 32'(frame_err), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        idle(50);

        // 0x55 with latency measurement from the start-bit falling edge
        exp_q.push_back(8'h55);
        exp_valid++;
        lat = 0;
        fork
            send(8'h55, 434, 1'b1, 10);
            begin
                while (!valid && lat < 6000) begin
                    @(negedge clock50);
                    lat++;
                end
            end
        join
        check("latency_window", 32'((lat >= 4080) && (lat <= 4170)), 32'd1);
        check("t1_data", 32'(data), 32'h55);
        wait_not_busy("t1_busy_low");
        check("t1_pending", 32'(exp_q.size()), 32'd0);
        idle(200);

        // Back-to-back 0x00, 0xFF
        v0 = valid_cnt;
        send_good(8'h00, 434);
        send_good(8'hFF, 434);
        idle(100);
        check("t2_valid_count", 32'(valid_cnt - v0), 32'd2);
        check("t2_data", 32'(data), 32'hFF);

        // Start-bit glitch
        v0 = valid_cnt;
        f0 = ferr_cnt;
        rx = 1'b0;
        repeat (100) @(negedge clock50);
        idle(400);
        check("t3_busy", 32'(busy), 32'd0);
        check("t3_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("t3_no_ferr", 32'(ferr_cnt - f0), 32'd0);

        // Bad stop bit then line break
        exp_ferr++;
        send(8'hA5, 434, 1'b0, 10);
        rx = 1'b0;
        repeat (2000) @(negedge clock50);
        check("t4_wait_hi_busy", 32'(busy), 32'd1);
        check("t4_ferr_count", 32'(ferr_cnt), 32'(exp_ferr));
        check("t4_data_held", 32'(data), 32'hFF);
        idle(100);
        wait_not_busy("t4_busy_low");
        send_good(8'h3C, 434);
        idle(100);
        check("t4_next_data", 32'(data), 32'h3C);

        // Reset during bit 4 of 0x81
        send(8'h81, 434, 1'b1, 5);
        rx = 1'b0;
        repeat (200) @(negedge clock50);
        reset = 1'b1;
        rx    = 1'b1;
        repeat (5) @(negedge clock50);
        check("t5_reset_data", 32'(data), 32'd0);
        check("t5_reset_busy", 32'(busy), 32'd0);
        last_good = 8'd0;
        reset = 1'b0;
        idle(500);
        check("t5_no_output", 32'(data), 32'd0);
        send_good(8'h12, 434);
        idle(100);
        check("t5_data", 32'(data), 32'h12);

        // Baud tolerance extremes, back-to-back
        send_good(8'hC3, 424);
        send_good(8'h5A, 424);
        send_good(8'h96, 443);
        send_good(8'h69, 443);
        idle(100);

        // Randomized frames, occasional bad stop bit
        for (int i = 0; i < 4; i++) begin
            b   = 8'($urandom);
            per = int'($urandom_range(424, 443));
            if ($urandom_range(0, 3) == 0) begin
                exp_ferr++;
                send(b, per, 1'b0, 10);
                rx = 1'b0;
                repeat ($urandom_range(0, 600)) @(negedge clock50);
                idle(2 * per);
            end else begin
                send_good(b, per);
                idle(int'($urandom_range(0, 2)) * per);
            end
        end
        idle(200);

        wait_not_busy("final_busy_low");
        check("final_pending", 32'(exp_q.size()), 32'd0);
        check("final_valid_count", 32'(valid_cnt), 32'(exp_valid));
        check("final_ferr_count", 32'(ferr_cnt), 32'(exp_ferr));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
